hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum memory-wait cycles before abort.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 src1, src2  input  4 each  ID-stage source register numbers.
REQ-007 two_src  input  1  src2 is a true operand.
REQ-008 exe_wb_en, exe_mem_r_en  input  1 each  EX instruction writes back / is a load.
REQ-009 exe_dest  input  4  EX destination register.
REQ-010 mem_wb_en  input  1  MEM instruction writes back.
REQ-011 mem_dest  input  4  MEM destination register.
REQ-012 branch_taken  input  1  EX stage resolved a taken branch.
REQ-013 mem_req, mem_ready  input  1 each  MEM-stage data-memory request / completion.
REQ-014 hazard_freeze  output  1  freeze for PC and IF-stage register.
REQ-015 bubble  output  1  zero the control bits entering the ID/EX register.
REQ-016 flush  output  1  flush for IF-stage register (and ID/EX bubble).
REQ-017 freeze_all  output  1  freeze for every pipeline register.
REQ-018 mem_error  output  1  sticky memory-timeout flag.
REQ-019 stall_count  output  CNT_W  stall-cycle performance counter.

Function
REQ-020 raw_exe SHALL be exe_wb_en and (src1==exe_dest or (two_src and src2==exe_dest)); raw_mem SHALL be defined likewise with mem_wb_en/mem_dest.
REQ-021 States: RUN and MEM_WAIT, 1-bit encoded.
REQ-022 RUN -> MEM_WAIT when mem_req=1 and mem_ready=0; MEM_WAIT -> RUN when mem_ready=1 or the wait counter equals TIMEOUT_CYCLES-1.
REQ-023 freeze_all SHALL be 1 combinationally whenever mem_req=1 and mem_ready=0 and the wait counter has not timed out, in either state.
REQ-024 Wait counter SHALL clear in RUN and increment by 1 per cycle in MEM_WAIT.
REQ-025 On timeout, mem_error SHALL set on that edge and remain 1 until reset; FSM SHALL return to RUN and freeze_all SHALL drop for that cycle.
REQ-026 flush SHALL equal branch_taken and not freeze_all; a branch during freeze_all SHALL be deferred until freeze_all drops.
REQ-027 hazard_freeze and bubble SHALL be 1 when the data hazard (REQ-040/041) holds, freeze_all=0 and flush=0.
REQ-028 Priority: freeze_all over flush over hazard; at most one of {freeze_all, flush, hazard_freeze} SHALL be 1 in any cycle.
REQ-029 bubble SHALL be 1 when flush=1.
REQ-030 Decision latency is zero cycles: outputs for a cycle depend on that cycle's inputs and registered state.
REQ-031 stall_count SHALL increment by 1 on each edge where freeze_all or hazard_freeze is 1, saturating at all-ones.
REQ-032 All combinational outputs SHALL be 0 when id_valid=0, except freeze_all and flush.

Reset
REQ-033 rst=1 SHALL immediately force state RUN, wait counter 0, mem_error 0, stall_count 0, independent of clk.
REQ-034 Reset asserted during MEM_WAIT SHALL abandon the wait; no deferred flush SHALL be remembered.
REQ-035 After deassertion, the first rising edge SHALL behave as in RUN.

Configuration
REQ-040 With FORWARDING_EN defined: data hazard = id_valid and exe_mem_r_en and raw_exe (load-use only).
REQ-041 Without FORWARDING_EN: data hazard = id_valid and (raw_exe or raw_mem).

Verification
REQ-050 Without FORWARDING_EN: exe_wb_en=1, exe_dest=3, src1=3, id_valid=1 -> hazard_freeze=1, bubble=1, stall_count +1.
REQ-051 With FORWARDING_EN: same stimulus, exe_mem_r_en=0 -> hazard_freeze=0; exe_mem_r_en=1 -> hazard_freeze=1.
REQ-052 branch_taken=1 together with the REQ-050 hazard -> flush=1, bubble=1, hazard_freeze=0.
REQ-053 mem_req=1, mem_ready=0 for 4 cycles then 1 -> freeze_all=1 for exactly 4 cycles, FSM back to RUN, stall_count=4.
REQ-054 TIMEOUT_CYCLES=8, mem_ready held 0 -> freeze_all high 8 cycles, then mem_error=1 sticky, state RUN.
REQ-055 rst pulse mid-MEM_WAIT with stall_count=5 -> stall_count=0, mem_error=0, freeze_all follows inputs immediately.

Source files
------------

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline hazard-control bus: ID/EX/MEM hazard inputs and stall/flush outputs.
interface hazard_ctrl_unit_if #(
   parameter int unsigned CNT_W = 16
);
   logic             id_valid;
   logic [3:0]       src1;
   logic [3:0]       src2;
   logic             two_src;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   logic [3:0]       exe_dest;
   logic             mem_wb_en;
   logic [3:0]       mem_dest;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             hazard_freeze;
   logic             bubble;
   logic             flush;
   logic             freeze_all;
   logic             mem_error;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, src1, src2, two_src, exe_wb_en, exe_mem_r_en, exe_dest,
             mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready,
      input  hazard_freeze, bubble, flush, freeze_all, mem_error, stall_count
   );

   modport slave (
      input  id_valid, src1, src2, two_src, exe_wb_en, exe_mem_r_en, exe_dest,
             mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready,
      output hazard_freeze, bubble, flush, freeze_all, mem_error, stall_count
   );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: RAW stalls, branch flush, memory-wait freeze with timeout.
// Optional macro FORWARDING_EN limits data hazards to load-use only.
module hazard_ctrl_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 16
) (
   input logic              clk,
   input logic              rst,
   hazard_ctrl_unit_if.slave bus
);
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t           state;
   logic [WW-1:0]    wait_cnt;
   logic             branch_pend;
   logic             mem_error;
   logic [CNT_W-1:0] stall_count;

   logic raw_exe, raw_mem, hazard, timeout;
   logic freeze_all, flush, hazard_freeze, bubble;

   assign raw_exe = bus.exe_wb_en &
                    ((bus.src1 == bus.exe_dest) | (bus.two_src & (bus.src2 == bus.exe_dest)));
   assign raw_mem = bus.mem_wb_en &
                    ((bus.src1 == bus.mem_dest) | (bus.two_src & (bus.src2 == bus.mem_dest)));

`ifdef FORWARDING_EN
   assign hazard = bus.id_valid & bus.exe_mem_r_en & raw_exe;
`else
   assign hazard = bus.id_valid & (raw_exe | raw_mem);
`endif

   assign timeout       = (state == MEM_WAIT) && (wait_cnt == WW'(TIMEOUT_CYCLES - 1));
   assign freeze_all    = bus.mem_req & ~bus.mem_ready & ~timeout;
   // A branch seen while frozen is held in branch_pend and flushed once the freeze lifts
   assign flush         = (bus.branch_taken | branch_pend) & ~freeze_all;
   assign hazard_freeze = hazard & ~freeze_all & ~flush;
   assign bubble        = bus.id_valid & (hazard_freeze | flush);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         branch_pend <= 1'b0;
         mem_error   <= 1'b0;
         stall_count <= '0;
      end else begin
         branch_pend <= freeze_all & (bus.branch_taken | branch_pend);
         if ((freeze_all | hazard_freeze) && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
         case (state)
            RUN: begin
               wait_cnt <= '0;
               if (bus.mem_req & ~bus.mem_ready)
                  state <= MEM_WAIT;
            end
            MEM_WAIT: begin
               if (bus.mem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (timeout) begin
                  state     <= RUN;
                  wait_cnt  <= '0;
                  mem_error <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.freeze_all    = freeze_all;
   assign bus.flush         = flush;
   assign bus.hazard_freeze = hazard_freeze;
   assign bus.bubble        = bubble;
   assign bus.mem_error     = mem_error;
   assign bus.stall_count   = stall_count;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit (TIMEOUT_CYCLES=8).
module tb_hazard_ctrl_unit;
   localparam int unsigned CNT_W = 16;
`ifdef FORWARDING_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   exp_cnt = 0;
   logic st;

   hazard_ctrl_unit_if #(.CNT_W(CNT_W)) bus ();

   hazard_ctrl_unit #(.TIMEOUT_CYCLES(8), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.id_valid = 0; bus.src1 = 0; bus.src2 = 0; bus.two_src = 0;
      bus.exe_wb_en = 0; bus.exe_mem_r_en = 0; bus.exe_dest = 0;
      bus.mem_wb_en = 0; bus.mem_dest = 0; bus.branch_taken = 0;
      bus.mem_req = 0; bus.mem_ready = 0;
   endtask

   task automatic step();
      @(posedge clk); @(negedge clk); #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      bus.src1 = 4'd7; bus.exe_dest = 4'd9;
      rst = 1; #3;
      tests++; if (bus.stall_count !== '0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_count); end
      tests++; if (bus.mem_error !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", bus.mem_error); end
      tests++; if ({bus.freeze_all, bus.flush, bus.hazard_freeze, bus.bubble} !== 4'b0000) begin
         fails++; $display("FAIL reset_outs: got %b want 0000", {bus.freeze_all, bus.flush, bus.hazard_freeze, bus.bubble}); end
      @(negedge clk); rst = 0; #1;
      exp_cnt = 0;
   endtask

   task automatic test_raw_exe();
      clear_inputs();
      bus.id_valid = 1; bus.exe_wb_en = 1; bus.exe_dest = 4'd3; bus.src1 = 4'd3; #1;
      tests++; if (bus.hazard_freeze !== ~FWD) begin fails++; $display("FAIL exe_alu_hf: got %0b want %0b", bus.hazard_freeze, ~FWD); end
      tests++; if (bus.bubble !== ~FWD) begin fails++; $display("FAIL exe_alu_bubble: got %0b want %0b", bus.bubble, ~FWD); end
      if (!FWD) exp_cnt++;
      step();
      tests++; if (bus.stall_count !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL exe_alu_cnt: got %0d want %0d", bus.stall_count, exp_cnt); end
      bus.exe_mem_r_en = 1; #1;
      tests++; if (bus.hazard_freeze !== 1'b1) begin fails++; $display("FAIL exe_load_hf: got %0b want 1", bus.hazard_freeze); end
      exp_cnt++;
      step();
      tests++; if (bus.stall_count !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL exe_load_cnt: got %0d want %0d", bus.stall_count, exp_cnt); end
      bus.src1 = 4'd4; #1;
      tests++; if (bus.hazard_freeze !== 1'b0) begin fails++; $display("FAIL exe_nomatch_hf: got %0b want 0", bus.hazard_freeze); end
   endtask

   task automatic test_raw_mem();
      clear_inputs();
      bus.id_valid = 1; bus.mem_wb_en = 1; bus.mem_dest = 4'd5; bus.src1 = 4'd1;
      bus.src2 = 4'd5; bus.two_src = 1; #1;
      tests++; if (bus.hazard_freeze !== ~FWD) begin fails++; $display("FAIL mem_src2_hf: got %0b want %0b", bus.hazard_freeze, ~FWD); end
      if (!FWD) exp_cnt++;
      step();
      bus.two_src = 0; #1;
      tests++; if (bus.hazard_freeze !== 1'b0) begin fails++; $display("FAIL mem_one_src_hf: got %0b want 0", bus.hazard_freeze); end
      bus.two_src = 1; bus.id_valid = 0; bus.exe_wb_en = 1; bus.exe_mem_r_en = 1; bus.exe_dest = 4'd1; #1;
      tests++; if ({bus.hazard_freeze, bus.bubble} !== 2'b00) begin fails++; $display("FAIL idle_outs: got %b want 00", {bus.hazard_freeze, bus.bubble}); end
      step();
      tests++; if (bus.stall_count !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL mem_cnt: got %0d want %0d", bus.stall_count, exp_cnt); end
   endtask

   task automatic test_flush();
      clear_inputs();
      bus.id_valid = 1; bus.exe_wb_en = 1; bus.exe_mem_r_en = 1; bus.exe_dest = 4'd3; bus.src1 = 4'd3;
      bus.branch_taken = 1; #1;
      tests++; if ({bus.flush, bus.bubble, bus.hazard_freeze} !== 3'b110) begin
         fails++; $display("FAIL flush_prio: got %b want 110", {bus.flush, bus.bubble, bus.hazard_freeze}); end
      step();
      tests++; if (bus.stall_count !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL flush_cnt: got %0d want %0d", bus.stall_count, exp_cnt); end
      bus.mem_req = 1; #1;
      tests++; if ({bus.freeze_all, bus.flush, bus.hazard_freeze} !== 3'b100) begin
         fails++; $display("FAIL freeze_prio: got %b want 100", {bus.freeze_all, bus.flush, bus.hazard_freeze}); end
      bus.mem_ready = 1; #1;
      tests++; if ({bus.freeze_all, bus.flush} !== 2'b01) begin fails++; $display("FAIL ready_flush: got %b want 01", {bus.freeze_all, bus.flush}); end
      step();
      clear_inputs(); #1;
   endtask

   task automatic test_mem_wait();
      clear_inputs();
      bus.mem_req = 1; bus.branch_taken = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if ({bus.freeze_all, bus.flush} !== 2'b10) begin
            fails++; $display("FAIL wait_freeze[%0d]: got %b want 10", i, {bus.freeze_all, bus.flush}); end
         step();
         bus.branch_taken = 0;
      end
      exp_cnt += 4;
      bus.mem_ready = 1; #1;
      tests++; if ({bus.freeze_all, bus.flush} !== 2'b01) begin fails++; $display("FAIL wait_release: got %b want 01", {bus.freeze_all, bus.flush}); end
      step();
      clear_inputs(); #1;
      st = dut.state;
      tests++; if (st !== 1'b0) begin fails++; $display("FAIL wait_state: got %0b want 0", st); end
      tests++; if (bus.flush !== 1'b0) begin fails++; $display("FAIL wait_flush_once: got %0b want 0", bus.flush); end
      tests++; if (bus.stall_count !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL wait_cnt: got %0d want %0d", bus.stall_count, exp_cnt); end
   endtask

   task automatic test_timeout();
      clear_inputs();
      bus.mem_req = 1;
      for (int i = 0; i < 8; i++) begin
         #1;
         tests++; if (bus.freeze_all !== 1'b1) begin fails++; $display("FAIL to_freeze[%0d]: got %0b want 1", i, bus.freeze_all); end
         step();
      end
      exp_cnt += 8;
      #1;
      tests++; if ({bus.freeze_all, bus.mem_error} !== 2'b00) begin fails++; $display("FAIL to_edge: got %b want 00", {bus.freeze_all, bus.mem_error}); end
      step();
      bus.mem_req = 0; #1;
      st = dut.state;
      tests++; if ({bus.mem_error, st} !== 2'b10) begin fails++; $display("FAIL to_after: got %b want 10", {bus.mem_error, st}); end
      step(); step();
      tests++; if (bus.mem_error !== 1'b1) begin fails++; $display("FAIL to_sticky: got %0b want 1", bus.mem_error); end
      tests++; if (bus.stall_count !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL to_cnt: got %0d want %0d", bus.stall_count, exp_cnt); end
   endtask

   task automatic test_reset_mid_wait();
      clear_inputs();
      bus.mem_req = 1; bus.branch_taken = 1;
      step();
      bus.branch_taken = 0;
      step(); step(); step();
      exp_cnt += 4;
      tests++; if (bus.stall_count !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL rmw_precnt: got %0d want %0d", bus.stall_count, exp_cnt); end
      rst = 1; #1;
      tests++; if ({bus.stall_count, bus.mem_error} !== {CNT_W'(0), 1'b0}) begin
         fails++; $display("FAIL rmw_clear: got %0d/%0b want 0/0", bus.stall_count, bus.mem_error); end
      tests++; if ({bus.freeze_all, bus.flush} !== 2'b10) begin fails++; $display("FAIL rmw_freeze_in: got %b want 10", {bus.freeze_all, bus.flush}); end
      bus.mem_req = 0; #1;
      tests++; if ({bus.freeze_all, bus.flush} !== 2'b00) begin fails++; $display("FAIL rmw_no_pend: got %b want 00", {bus.freeze_all, bus.flush}); end
      step();
      rst = 0; #1;
      bus.mem_req = 1; #1;
      tests++; if (bus.freeze_all !== 1'b1) begin fails++; $display("FAIL rmw_run_freeze: got %0b want 1", bus.freeze_all); end
      step();
      st = dut.state;
      tests++; if ({bus.stall_count, st} !== {CNT_W'(1), 1'b1}) begin
         fails++; $display("FAIL rmw_first_edge: got %0d/%0b want 1/1", bus.stall_count, st); end
      bus.mem_ready = 1; step();
      clear_inputs(); #1;
   endtask

   initial begin
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_raw_exe();
      test_raw_mem();
      test_flush();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end
endmodule
